// File: rtl/lsu_mem_arb_pkg.sv
// Shared types for the LSU data-memory arbiter: master ids and the memory command payload.
package lsu_mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef logic master_id_t;

    localparam master_id_t MID_M0 = 1'b0;
    localparam master_id_t MID_M1 = 1'b1;

    typedef struct packed {
        logic              wren;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } mem_cmd_t;

endpackage

// File: rtl/lsu_arb_tag_fifo.sv
// Tag FIFO recording which master issued each outstanding read, in grant order.
module lsu_arb_tag_fifo
    import lsu_mem_arb_pkg::*;
#(
    parameter int unsigned P_DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       push,
    input  logic                       pop,
    input  master_id_t                 din,
    output master_id_t                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(P_DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(P_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    master_id_t        mem_q [P_DEPTH];
    master_id_t        mem_d [P_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mem_q    <= '{default: MID_M0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(P_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Two-master arbiter for the LSU data-memory port; routes in-order read responses back
// to their originator using a tag FIFO.
module lsu_mem_arbiter
    import lsu_mem_arb_pkg::*;
#(
    parameter int unsigned P_MAX_OUTST  = 4,
    parameter int unsigned P_FIXED_PRIO = 0
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_m0_req,
    input  logic              i_m0_wren,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic [STRB_W-1:0] i_m0_strb,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_wren,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic [STRB_W-1:0] i_m1_strb,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_mem_req,
    output logic              o_mem_wren,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [STRB_W-1:0] o_mem_strb,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_err
);

    localparam int unsigned CNT_W = $clog2(P_MAX_OUTST) + 1;

    mem_cmd_t          m0_cmd, m1_cmd, sel_cmd, out_cmd;
    logic              read_ok, m0_ok, m1_ok;
    logic              pref_m1, sel_m1;
    logic              grant, push, pop;
    master_id_t        last_grant_q, last_grant_d;
    logic              err_q, err_d;
    master_id_t        head;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // Selection, command mux, grant and response routing.
    always_comb begin
        m0_cmd = '{wren: i_m0_wren, addr: i_m0_addr, wdata: i_m0_wdata, strb: i_m0_strb};
        m1_cmd = '{wren: i_m1_wren, addr: i_m1_addr, wdata: i_m1_wdata, strb: i_m1_strb};

        // Pre-pop occupancy: a response popping this cycle does not open a slot yet.
        read_ok = !fifo_full;
        m0_ok   = i_m0_req && (i_m0_wren || read_ok);
        m1_ok   = i_m1_req && (i_m1_wren || read_ok);

        if (i_m0_req && i_m1_req) begin
            pref_m1 = (P_FIXED_PRIO != 0) ? 1'b0 : (last_grant_q == MID_M0);
        end else begin
            pref_m1 = i_m1_req;
        end

        // A preferred read stalled on a full tag FIFO yields to the other master.
        sel_m1 = pref_m1;
        if (pref_m1 && !m1_ok && m0_ok) begin
            sel_m1 = 1'b0;
        end else if (!pref_m1 && !m0_ok && m1_ok) begin
            sel_m1 = 1'b1;
        end

        sel_cmd   = sel_m1 ? m1_cmd : m0_cmd;
        o_mem_req = i_rstn && (sel_m1 ? m1_ok : m0_ok);
        out_cmd   = o_mem_req ? sel_cmd : '0;

        o_mem_wren  = out_cmd.wren;
        o_mem_addr  = out_cmd.addr;
        o_mem_wdata = out_cmd.wdata;
        o_mem_strb  = out_cmd.strb;

        grant    = o_mem_req && i_mem_ready;
        o_m0_gnt = grant && !sel_m1;
        o_m1_gnt = grant && sel_m1;
        push     = grant && !sel_cmd.wren;

        last_grant_d = last_grant_q;
        if (grant) begin
            last_grant_d = sel_m1 ? MID_M1 : MID_M0;
        end

        pop         = i_rstn && i_mem_rvalid && (fifo_count != '0);
        o_m0_rvalid = pop && (head == MID_M0);
        o_m1_rvalid = pop && (head == MID_M1);
        o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
        o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;

        err_d = err_q || (i_mem_rvalid && fifo_empty);
        o_err = err_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            last_grant_q <= MID_M1;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    lsu_arb_tag_fifo #(
        .P_DEPTH (P_MAX_OUTST)
    ) u_tag_fifo (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .push   (push),
        .pop    (pop),
        .din    (sel_m1 ? MID_M1 : MID_M0),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
- Shares the single data-memory port behind the LSU data region (0x2000–0x20FF today, SDRAM controller later) between two requesters.
  - M0: CPU LSU.
  - M1: DMA/debug loader.
- Arbitrates per request, forwards the command to the memory, and tracks outstanding reads so each read response returns to its originator.
- Writes are posted. Read responses may arrive with variable latency, in order.

Parameters:
- P_MAX_OUTST, 4, maximum outstanding reads. Power of two, 2..16.
- P_FIXED_PRIO, 0: 0 = round-robin; 1 = M0 always wins.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_m0_req  in  1  M0 request valid; held with fields stable until granted
- i_m0_wren  in  1  M0 write (1) / read (0)
- i_m0_addr  in  32  M0 byte address
- i_m0_wdata  in  32  M0 write data, lane-aligned
- i_m0_strb  in  4  M0 byte strobes
- o_m0_gnt  out  1  M0 request accepted this cycle
- o_m0_rvalid  out  1  M0 read data valid, 1-cycle pulse
- o_m0_rdata  out  32  M0 read data
- i_m1_req / i_m1_wren / i_m1_addr / i_m1_wdata / i_m1_strb  in  1/1/32/32/4  M1 request, same semantics as M0
- o_m1_gnt / o_m1_rvalid / o_m1_rdata  out  1/1/32  M1 response, same semantics as M0
- o_mem_req  out  1  command valid to memory
- o_mem_wren  out  1  command write
- o_mem_addr  out  32  command address
- o_mem_wdata  out  32  command write data
- o_mem_strb  out  4  command strobes
- i_mem_ready  in  1  memory accepts command this cycle
- i_mem_rvalid  in  1  read response valid
- i_mem_rdata  in  32  read response data
- o_err  out  1  sticky: unexpected read response

Behaviour:
- Reset (async, i_rstn=0):
  - All outputs 0; tag FIFO empty; o_err=0.
  - last_grant=1, so M0 wins the first contention.
- Selection (combinational):
  - Only one master requesting: select it.
  - Both requesting:
    - P_FIXED_PRIO=1: select M0.
    - Otherwise: select the master not equal to last_grant.
- Command path:
  - o_mem_req=1 when any request exists and the request is allowed.
  - mem fields are muxed from the selected master; all mem fields are 0 when o_mem_req=0.
- Read allowance:
  - A read is allowed only when tag count < P_MAX_OUTST.
  - A pop in the same cycle does not free a slot.
  - A blocked read does not block the other master: if the selected master is a read blocked by full, and the other master requests a write, the write is selected instead.
- Grant:
  - o_mX_gnt = selected_X & o_mem_req & i_mem_ready.
  - Zero-latency accept: handshake completes in the cycle gnt=1.
  - last_grant updates on the clock edge of a grant only.
- Tag FIFO:
  - Granted read: push master id at the clock edge.
  - Granted write: no push.
- Response routing:
  - i_mem_rvalid=1 with FIFO non-empty: pop head; o_m{head}_rvalid=1 in the same cycle (combinational), o_m{head}_rdata=i_mem_rdata.
  - The other master's rvalid=0 and rdata=0.
  - i_mem_rvalid=1 with FIFO empty: no master rvalid; o_err set, sticky until reset.
- Simultaneous push and pop: both happen and count is unchanged. Grant eligibility still uses the pre-pop count.
- Ordering: memory is in-order, so responses return in grant order across both masters.
- Fairness: in round-robin mode, a continuously requesting master waits at most one grant.
- Request withdrawn before grant: not permitted; the bench flags it as an assertion.
- Reset mid-operation:
  - Outstanding tags are discarded.
  - Late responses after reset set o_err.

Decomposition:
- Shared package lsu_mem_arb_pkg:
  - typedef master_id_t (1 bit), with constants MID_M0 and MID_M1.
  - typedef mem_cmd_t (packed struct: wren, addr, wdata, strb).
- One sub-module, lsu_arb_tag_fifo:
  - Synchronous FIFO of master_id_t, depth P_MAX_OUTST.
  - Ports: push, pop, din, dout, full, empty, count.
  - Asynchronous active-low reset.

Test Plan:
1. Single read: M0 read 0x2004, i_mem_ready=1, response 2 cycles later with 0xDEADBEEF -> o_m0_gnt in cycle 0, o_m0_rvalid with 0xDEADBEEF in cycle 2, M1 rvalid stays 0.
2. Contention, round-robin: both masters hold reads for 4 cycles, ready=1 -> grant order M0, M1, M0, M1; four responses A, B, C, D route to M0, M1, M0, M1 respectively.
3. Fixed priority, P_FIXED_PRIO=1: both masters request continuously -> M0 granted every cycle; M1 granted only when M0 deasserts.
4. Outstanding limit, P_MAX_OUTST=4:
   - 4 M1 reads with no responses -> 5th read not granted.
   - An M0 write of 0x11223344, strb 0xF, is granted meanwhile.
   - One response -> the 5th read is granted the next cycle.
5. Backpressure: i_mem_ready=0 for 3 cycles with M0 write pending -> no gnt and command stable; gnt in the cycle ready returns.
6. Error and reset: i_mem_rvalid with FIFO empty -> o_err=1 and stays 1. Then assert i_rstn=0 with 2 reads outstanding -> all outputs 0, FIFO empty, o_err cleared.
